// File: rtl/fs_corner_collector_if.sv
// fs_corner_collector_if: bundles the score-stage input, the readout
// handshake and the per-frame status outputs of fs_corner_collector.
// master = the collector itself, slave = score stage / host side.
interface fs_corner_collector_if #(
  parameter int ADDR_W  = 17,
  parameter int SCORE_W = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
);
  localparam int FILL_W = $clog2(DEPTH) + 1;

  // Score stage side
  logic               frameStart;
  logic               isCorner;
  logic [ADDR_W-1:0]  refAddr;
  logic [SCORE_W-1:0] scoreValue;
  logic [SCORE_W-1:0] minScore;

  // Readout side
  logic               outValid;
  logic               outReady;
  logic [ADDR_W-1:0]  outAddr;
  logic [SCORE_W-1:0] outScore;

  // Status
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   cornerCount;
  logic [CNT_W-1:0]   dropCount;
  logic [SCORE_W-1:0] maxScore;
  logic [ADDR_W-1:0]  maxAddr;

  modport master (
    input  frameStart, isCorner, refAddr, scoreValue, minScore, outReady,
    output outValid, outAddr, outScore, fill, cornerCount, dropCount,
           maxScore, maxAddr
  );

  modport slave (
    output frameStart, isCorner, refAddr, scoreValue, minScore, outReady,
    input  outValid, outAddr, outScore, fill, cornerCount, dropCount,
           maxScore, maxAddr
  );
endinterface

// File: rtl/fs_corner_collector.sv
// fs_corner_collector: filters FAST-9 corners against a runtime minimum score
// and queues (address, score) pairs in a FIFO drained by a valid/ready port.
// Keeps saturating per-frame accepted/dropped counters.
// Optional feature macro FS_COLLECT_MAX_EN: tracks the highest accepted score
// of the frame and its address; when undefined those outputs are tied to 0.
module fs_corner_collector #(
  parameter int ADDR_W  = 17,
  parameter int SCORE_W = 8,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input logic                clock,
  input logic                reset,
  fs_corner_collector_if.master bus
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = PTR_W + 1;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  // Saturating increment for the per-frame counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Storage (data only, never reset: occupancy decides what is live)
  logic [ADDR_W-1:0]  mem_addr_q  [DEPTH];
  logic [SCORE_W-1:0] mem_score_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic [SCORE_W-1:0] out_score_q, out_score_d;
  logic [CNT_W-1:0]   corner_cnt_q, corner_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               cand;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   rd_next;

  // Classify this cycle: candidate, pop, push or drop.
  always_comb begin
    cand    = bus.isCorner && (bus.scoreValue >= bus.minScore);
    full    = (fill_q == FILL_FULL);
    pop     = out_valid_q && bus.outReady;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push    = cand && (!full || pop);
    drop    = cand && full && !pop;
    rd_next = rd_ptr_q + PTR_ONE;
    // frameStart restarts the queue, so its candidate always lands in slot 0.
    if (bus.frameStart) begin
      wr_en  = cand;
      wr_idx = '0;
    end else begin
      wr_en  = push;
      wr_idx = wr_ptr_q;
    end
  end

  // Next-state for pointers, occupancy, head register and counters.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_score_d  = out_score_q;
    corner_cnt_d = corner_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    if (bus.frameStart) begin
      // Any pop requested now is discarded along with the old frame.
      rd_ptr_d = '0;
      if (cand) begin
        wr_ptr_d     = PTR_ONE;
        fill_d       = FILL_ONE;
        out_valid_d  = 1'b1;
        out_addr_d   = bus.refAddr;
        out_score_d  = bus.scoreValue;
        corner_cnt_d = CNT_ONE;
      end else begin
        wr_ptr_d     = '0;
        fill_d       = '0;
        out_valid_d  = 1'b0;
        corner_cnt_d = '0;
      end
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_next;

      case ({push, pop})
        2'b10:   fill_d = fill_q + FILL_ONE;
        2'b01:   fill_d = fill_q - FILL_ONE;
        default: fill_d = fill_q;
      endcase
      out_valid_d = (fill_d != '0);

      // Head register only moves on a pop or on a push into an empty FIFO.
      if (pop) begin
        if (fill_q > FILL_ONE) begin
          out_addr_d  = mem_addr_q[rd_next];
          out_score_d = mem_score_q[rd_next];
        end else if (push) begin
          out_addr_d  = bus.refAddr;
          out_score_d = bus.scoreValue;
        end
      end else if (push && (fill_q == '0)) begin
        out_addr_d  = bus.refAddr;
        out_score_d = bus.scoreValue;
      end

      if (push) corner_cnt_d = sat_inc(corner_cnt_q);
      if (drop) drop_cnt_d   = sat_inc(drop_cnt_q);
    end
  end

  // Write accepted corners into the storage array.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem_addr_q[wr_idx]  <= bus.refAddr;
      mem_score_q[wr_idx] <= bus.scoreValue;
    end
  end

  // Control, head and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_score_q  <= '0;
      corner_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_score_q  <= out_score_d;
      corner_cnt_q <= corner_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.outValid    = out_valid_q;
  assign bus.outAddr     = out_addr_q;
  assign bus.outScore    = out_score_q;
  assign bus.fill        = fill_q;
  assign bus.cornerCount = corner_cnt_q;
  assign bus.dropCount   = drop_cnt_q;

`ifdef FS_COLLECT_MAX_EN
  logic [SCORE_W-1:0] max_score_q, max_score_d;
  logic [ADDR_W-1:0]  max_addr_q, max_addr_d;

  // Strictly-greater update keeps the earliest corner on ties.
  always_comb begin
    max_score_d = max_score_q;
    max_addr_d  = max_addr_q;
    if (bus.frameStart) begin
      if (cand) begin
        max_score_d = bus.scoreValue;
        max_addr_d  = bus.refAddr;
      end else begin
        max_score_d = '0;
        max_addr_d  = '0;
      end
    end else if (push && (bus.scoreValue > max_score_q)) begin
      max_score_d = bus.scoreValue;
      max_addr_d  = bus.refAddr;
    end
  end

  // Max tracker registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      max_score_q <= '0;
      max_addr_q  <= '0;
    end else begin
      max_score_q <= max_score_d;
      max_addr_q  <= max_addr_d;
    end
  end

  assign bus.maxScore = max_score_q;
  assign bus.maxAddr  = max_addr_q;
`else
  assign bus.maxScore = '0;
  assign bus.maxAddr  = '0;
`endif

endmodule

// File: tb/tb_fs_corner_collector.sv
// tb_fs_corner_collector: directed test of fs_corner_collector with
// hand-computed expectations (DEPTH=16, 8-bit scores, 17-bit addresses).
module tb_fs_corner_collector;

`ifdef FS_COLLECT_MAX_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fs_corner_collector_if #(.ADDR_W(17), .SCORE_W(8), .DEPTH(16), .CNT_W(16)) bif ();

  fs_corner_collector #(.ADDR_W(17), .SCORE_W(8), .DEPTH(16), .CNT_W(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic corner(input logic [16:0] a, input logic [7:0] s);
    bif.isCorner   = 1'b1;
    bif.refAddr    = a;
    bif.scoreValue = s;
    cyc();
    bif.isCorner   = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".valid"}, 32'(bif.outValid),    32'h0);
    chk({tag, ".fill"},  32'(bif.fill),        32'h0);
    chk({tag, ".ccnt"},  32'(bif.cornerCount), 32'h0);
    chk({tag, ".dcnt"},  32'(bif.dropCount),   32'h0);
    chk({tag, ".maxs"},  32'(bif.maxScore),    32'h0);
    chk({tag, ".maxa"},  32'(bif.maxAddr),     32'h0);
    chk({tag, ".addr"},  32'(bif.outAddr),     32'h0);
    chk({tag, ".score"}, 32'(bif.outScore),    32'h0);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bif.frameStart = 1'b0;
    bif.isCorner   = 1'b0;
    bif.refAddr    = '0;
    bif.scoreValue = '0;
    bif.minScore   = 8'h10;
    bif.outReady   = 1'b0;
    cyc();
    cyc();
    chk_reset_state("reset");
    rst = 1'b0;

    // Basic queue with threshold filter
    bif.outReady = 1'b1;
    corner(17'd5, 8'h20);
    chk("basic.v1",  32'(bif.outValid), 32'h1);
    chk("basic.a1",  32'(bif.outAddr),  32'd5);
    chk("basic.s1",  32'(bif.outScore), 32'h20);
    corner(17'd9, 8'h0F);
    chk("basic.v0",  32'(bif.outValid), 32'h0);
    corner(17'd12, 8'h10);
    chk("basic.v2",  32'(bif.outValid), 32'h1);
    chk("basic.a2",  32'(bif.outAddr),  32'd12);
    chk("basic.s2",  32'(bif.outScore), 32'h10);
    cyc();
    chk("basic.fill", 32'(bif.fill),        32'h0);
    chk("basic.ccnt", 32'(bif.cornerCount), 32'd2);
    chk("basic.dcnt", 32'(bif.dropCount),   32'd0);

    // Overflow: 20 corners into a 16-entry FIFO
    bif.outReady   = 1'b0;
    bif.frameStart = 1'b1;
    cyc();
    bif.frameStart = 1'b0;
    chk("frame.clr", 32'(bif.cornerCount), 32'd0);
    for (int i = 0; i < 20; i++) corner(17'(i), 8'hFF);
    chk("ovf.fill",  32'(bif.fill),        32'd16);
    chk("ovf.dcnt",  32'(bif.dropCount),   32'd4);
    chk("ovf.ccnt",  32'(bif.cornerCount), 32'd16);
    chk("ovf.head",  32'(bif.outAddr),     32'd0);

    // Full with simultaneous pop: push accepted, fill unchanged
    bif.outReady = 1'b1;
    corner(17'd50, 8'hFF);
    chk("fwp.fill",  32'(bif.fill),        32'd16);
    chk("fwp.dcnt",  32'(bif.dropCount),   32'd4);
    chk("fwp.ccnt",  32'(bif.cornerCount), 32'd17);
    chk("fwp.head",  32'(bif.outAddr),     32'd1);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("drain.%0d", k), 32'(bif.outAddr), 32'(k));
      cyc();
    end
    chk("drain.last",  32'(bif.outAddr),  32'd50);
    cyc();
    chk("drain.fill",  32'(bif.fill),     32'd0);
    chk("drain.valid", 32'(bif.outValid), 32'd0);

    // Frame restart with a coincident candidate
    bif.outReady = 1'b0;
    for (int i = 1; i <= 3; i++) corner(17'(i), 8'h30);
    chk("fr.pre", 32'(bif.fill), 32'd3);
    bif.frameStart = 1'b1;
    corner(17'd100, 8'h40);
    bif.frameStart = 1'b0;
    chk("fr.fill",  32'(bif.fill),        32'd1);
    chk("fr.valid", 32'(bif.outValid),    32'd1);
    chk("fr.addr",  32'(bif.outAddr),     32'd100);
    chk("fr.score", 32'(bif.outScore),    32'h40);
    chk("fr.ccnt",  32'(bif.cornerCount), 32'd1);
    chk("fr.dcnt",  32'(bif.dropCount),   32'd0);
    chk("fr.maxs",  32'(bif.maxScore),    MAX_EN ? 32'h40 : 32'h0);
    chk("fr.maxa",  32'(bif.maxAddr),     MAX_EN ? 32'd100 : 32'h0);

    // Max tracker: ties keep the earlier corner
    bif.frameStart = 1'b1;
    cyc();
    bif.frameStart = 1'b0;
    corner(17'd1, 8'd30);
    corner(17'd2, 8'd50);
    corner(17'd3, 8'd50);
    corner(17'd4, 8'd20);
    chk("max.score", 32'(bif.maxScore),    MAX_EN ? 32'd50 : 32'd0);
    chk("max.addr",  32'(bif.maxAddr),     MAX_EN ? 32'd2 : 32'd0);
    chk("max.fill",  32'(bif.fill),        32'd4);
    chk("max.ccnt",  32'(bif.cornerCount), 32'd4);

    // Reset mid-stream
    for (int i = 5; i <= 7; i++) corner(17'(i), 8'h11);
    chk("rms.fill", 32'(bif.fill), 32'd7);
    bif.outReady = 1'b1;
    rst          = 1'b1;
    cyc();
    chk_reset_state("rms");
    rst          = 1'b0;
    bif.outReady = 1'b0;
    corner(17'd77, 8'h55);
    chk("post.valid", 32'(bif.outValid),    32'd1);
    chk("post.addr",  32'(bif.outAddr),     32'd77);
    chk("post.score", 32'(bif.outScore),    32'h55);
    chk("post.fill",  32'(bif.fill),        32'd1);
    chk("post.ccnt",  32'(bif.cornerCount), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
